// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the CR16-style control unit: opcodes, ext codes,
// branch conditions, PSR bit positions, result-mux selects and FSM states.
package cpu_defs_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_BCOND = 4'b1100;

  localparam logic [3:0] EXT_ADD = 4'b0101;
  localparam logic [3:0] EXT_SUB = 4'b1001;
  localparam logic [3:0] EXT_CMP = 4'b1011;
  localparam logic [3:0] EXT_AND = 4'b0001;
  localparam logic [3:0] EXT_OR  = 4'b0010;
  localparam logic [3:0] EXT_XOR = 4'b0011;
  localparam logic [3:0] EXT_MOV = 4'b1101;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_LO = 4'b1010;
  localparam logic [3:0] COND_HS = 4'b1011;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;

  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_N = 3;
  localparam int PSR_Z = 4;

  localparam logic [1:0] RES_SHIFT = 2'b00;
  localparam logic [1:0] RES_ALU   = 2'b01;
  localparam logic [1:0] RES_MEM   = 2'b10;
  localparam logic [1:0] RES_LINK  = 2'b11;

  typedef logic [3:0] state_t;
  localparam state_t S_FETCH  = 4'd0;
  localparam state_t S_DECODE = 4'd1;
  localparam state_t S_EXEC   = 4'd2;
  localparam state_t S_SHIFT  = 4'd3;
  localparam state_t S_MEMRD  = 4'd4;
  localparam state_t S_LOADWB = 4'd5;
  localparam state_t S_MEMWR  = 4'd6;
  localparam state_t S_BRANCH = 4'd7;
  localparam state_t S_JUMP   = 4'd8;
  localparam state_t S_JAL    = 4'd9;
  localparam state_t S_PCINC  = 4'd10;

  // The same code set names both R-type ext values and immediate opcodes.
  function automatic logic is_alu_code(input logic [3:0] code);
    return code inside {EXT_ADD, EXT_SUB, EXT_CMP, EXT_AND, EXT_OR, EXT_XOR, EXT_MOV};
  endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the control unit (master) and the datapath (slave).
interface cpu_control_fsm_if #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
);
  logic [WIDTH-1:0]   memdata;
  logic [7:0]         PSROut;
  logic               PCEN;
  logic               PSREN;
  logic               nextInstruction;
  logic               updateAddress;
  logic               StoreReg;
  logic               WriteData;
  logic               regWrite;
  logic               ZeroExtend;
  logic               PCinstruction;
  logic               SrcB;
  logic               shiftType;
  logic               resultEn;
  logic               jumpEN;
  logic               BranchEN;
  logic               jalEN;
  logic [WIDTH-1:0]   shiftDir;
  logic [7:0]         shiftAmt;
  logic [REGBITS-1:0] ALUcond;
  logic [1:0]         chooseResult;
  logic               illegal_op;

  modport master (
    input  memdata, PSROut,
    output PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData,
           regWrite, ZeroExtend, PCinstruction, SrcB, shiftType, resultEn,
           jumpEN, BranchEN, jalEN, shiftDir, shiftAmt, ALUcond, chooseResult,
           illegal_op
  );

  modport slave (
    output memdata, PSROut,
    input  PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData,
           regWrite, ZeroExtend, PCinstruction, SrcB, shiftType, resultEn,
           jumpEN, BranchEN, jalEN, shiftDir, shiftAmt, ALUcond, chooseResult,
           illegal_op
  );
endinterface

// File: rtl/cpu_control_fsm_branch_cond_eval.sv
// Evaluates a 4-bit branch/jump condition against the PSR flags.
module branch_cond_eval
  import cpu_defs_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [7:0] psr,
  output logic       take
);
  logic c, l, f, n, z;
  logic unused_psr_bits;

  assign c = psr[PSR_C];
  assign l = psr[PSR_L];
  assign f = psr[PSR_F];
  assign n = psr[PSR_N];
  assign z = psr[PSR_Z];
  assign unused_psr_bits = ^psr[7:5];

  always_comb begin
    case (cond)
      COND_EQ: take = z;
      COND_NE: take = !z;
      COND_CS: take = c;
      COND_CC: take = !c;
      COND_HI: take = l;
      COND_LS: take = !l;
      COND_GT: take = n;
      COND_LE: take = !n;
      COND_FS: take = f;
      COND_FC: take = !f;
      COND_LO: take = !l && !z;
      COND_HS: take = l || z;
      COND_LT: take = !n && !z;
      COND_GE: take = n || z;
      COND_UC: take = 1'b1;
      default: take = 1'b0;
    endcase
  end
endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle control unit: FETCH/DECODE then a per-class execute path,
// with Moore outputs derived from the state and the latched instruction.
module cpu_control_fsm
  import cpu_defs_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input logic               clk,
  input logic               reset,
  cpu_control_fsm_if.master ctl
);
  state_t           state, next_state;
  logic [WIDTH-1:0] ir;
  logic [3:0]       op, ext;
  logic             is_rtype, is_imm, is_shift, is_mem_op, is_bcond, is_legal;
  logic             take;
  logic [4:0]       imm5, shift_mag;

  assign op        = ir[15:12];
  assign ext       = ir[7:4];
  assign is_rtype  = (op == OP_RTYPE) && is_alu_code(ext);
  assign is_imm    = is_alu_code(op);
  assign is_shift  = (op == OP_SHIFT) && (ext[3:1] == 3'b000);
  assign is_mem_op = (op == OP_MEM) && (ext inside {EXT_LOAD, EXT_STOR, EXT_JAL, EXT_JCOND});
  assign is_bcond  = (op == OP_BCOND);
  assign is_legal  = is_rtype || is_imm || is_shift || is_mem_op || is_bcond;
  assign imm5      = {ir[4], ir[3:0]};
  assign shift_mag = imm5[4] ? (~imm5 + 5'd1) : imm5;

  branch_cond_eval u_cond (
    .cond (ir[11:8]),
    .psr  (ctl.PSROut),
    .take (take)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH) ir <= ctl.memdata;
    end
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        if (is_rtype || is_imm)                      next_state = S_EXEC;
        else if (is_shift)                           next_state = S_SHIFT;
        else if (is_mem_op && ext == EXT_LOAD)       next_state = S_MEMRD;
        else if (is_mem_op && ext == EXT_STOR)       next_state = S_MEMWR;
        else if (is_mem_op && ext == EXT_JAL)        next_state = S_JAL;
        else if (is_mem_op && ext == EXT_JCOND)      next_state = take ? S_JUMP : S_PCINC;
        else if (is_bcond)                           next_state = take ? S_BRANCH : S_PCINC;
        else                                         next_state = S_PCINC;
      end
      S_EXEC, S_SHIFT, S_LOADWB, S_MEMWR: next_state = S_PCINC;
      S_MEMRD:  next_state = S_LOADWB;
      default:  next_state = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held, even mid-instruction.
  always_comb begin
    ctl.PCEN            = 1'b0;
    ctl.PSREN           = 1'b0;
    ctl.nextInstruction = 1'b0;
    ctl.updateAddress   = 1'b0;
    ctl.StoreReg        = 1'b0;
    ctl.WriteData       = 1'b0;
    ctl.regWrite        = 1'b0;
    ctl.ZeroExtend      = 1'b0;
    ctl.PCinstruction   = 1'b0;
    ctl.SrcB            = 1'b0;
    ctl.shiftType       = 1'b0;
    ctl.resultEn        = 1'b0;
    ctl.jumpEN          = 1'b0;
    ctl.BranchEN        = 1'b0;
    ctl.jalEN           = 1'b0;
    ctl.shiftDir        = '0;
    ctl.shiftAmt        = '0;
    ctl.ALUcond         = '0;
    ctl.chooseResult    = RES_SHIFT;
    ctl.illegal_op      = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          ctl.updateAddress   = 1'b1;
          ctl.nextInstruction = 1'b1;
        end
        S_DECODE: ctl.illegal_op = !is_legal;
        S_EXEC: begin
          ctl.ALUcond      = REGBITS'(is_rtype ? ext : op);
          ctl.SrcB         = is_rtype;
          ctl.ZeroExtend   = !is_rtype && (op inside {EXT_AND, EXT_OR, EXT_XOR});
          ctl.chooseResult = RES_ALU;
          ctl.resultEn     = 1'b1;
          ctl.PSREN        = 1'b1;
          ctl.regWrite     = is_rtype ? (ext != EXT_CMP) : (op != EXT_CMP);
        end
        S_SHIFT: begin
          ctl.chooseResult = RES_SHIFT;
          ctl.shiftDir     = imm5[4] ? '0 : {WIDTH{1'b1}};
          ctl.shiftAmt     = {3'b000, shift_mag};
          ctl.regWrite     = 1'b1;
          ctl.resultEn     = 1'b1;
        end
        S_MEMRD: ctl.StoreReg = 1'b1;
        S_LOADWB: begin
          ctl.chooseResult = RES_MEM;
          ctl.regWrite     = 1'b1;
        end
        S_MEMWR: begin
          ctl.StoreReg  = 1'b1;
          ctl.WriteData = 1'b1;
        end
        S_BRANCH: begin
          ctl.PCEN     = 1'b1;
          ctl.BranchEN = 1'b1;
        end
        S_JUMP: begin
          ctl.PCEN   = 1'b1;
          ctl.jumpEN = 1'b1;
        end
        S_JAL: begin
          ctl.PCEN         = 1'b1;
          ctl.jalEN        = 1'b1;
          ctl.jumpEN       = 1'b1;
          ctl.chooseResult = RES_LINK;
          ctl.regWrite     = 1'b1;
        end
        S_PCINC: begin
          ctl.PCEN          = 1'b1;
          ctl.PCinstruction = 1'b1;
          ctl.updateAddress = 1'b1;
          ctl.resultEn      = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench: each directed instruction queues its per-cycle control
// words; a negedge monitor pops and compares one word per cycle.
module tb_cpu_control_fsm;
  typedef struct packed {
    logic        illegal_op, pcen, psren, next_instr, update_addr, store_reg,
                 write_data, reg_write, zero_ext, pc_instr, src_b, shift_type,
                 result_en, jump_en, branch_en, jal_en;
    logic [1:0]  choose_result;
    logic [3:0]  alu_cond;
    logic [7:0]  shift_amt;
    logic [15:0] shift_dir;
  } ctl_t;

  logic  clk;
  logic  reset;
  int    checks;
  int    errors;
  ctl_t  act;
  ctl_t  exp_q[$];
  string lbl_q[$];
  ctl_t  mon_exp;
  string mon_lbl;

  cpu_control_fsm_if #(.WIDTH(16), .REGBITS(4)) ctl ();

  cpu_control_fsm #(.WIDTH(16), .REGBITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (ctl.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = '{ctl.illegal_op, ctl.PCEN, ctl.PSREN, ctl.nextInstruction,
                 ctl.updateAddress, ctl.StoreReg, ctl.WriteData, ctl.regWrite,
                 ctl.ZeroExtend, ctl.PCinstruction, ctl.SrcB, ctl.shiftType,
                 ctl.resultEn, ctl.jumpEN, ctl.BranchEN, ctl.jalEN,
                 ctl.chooseResult, ctl.ALUcond, ctl.shiftAmt, ctl.shiftDir};

  function automatic ctl_t w_fetch();
    ctl_t w = '0;
    w.update_addr = 1'b1;
    w.next_instr  = 1'b1;
    return w;
  endfunction

  function automatic ctl_t w_decode(input logic ill);
    ctl_t w = '0;
    w.illegal_op = ill;
    return w;
  endfunction

  function automatic ctl_t w_exec(input logic [3:0] alu, input logic srcb,
                                  input logic zext, input logic regw);
    ctl_t w = '0;
    w.alu_cond      = alu;
    w.src_b         = srcb;
    w.zero_ext      = zext;
    w.reg_write     = regw;
    w.choose_result = 2'b01;
    w.result_en     = 1'b1;
    w.psren         = 1'b1;
    return w;
  endfunction

  function automatic ctl_t w_shift(input logic [15:0] dir, input logic [7:0] amt);
    ctl_t w = '0;
    w.shift_dir = dir;
    w.shift_amt = amt;
    w.reg_write = 1'b1;
    w.result_en = 1'b1;
    return w;
  endfunction

  function automatic ctl_t w_memrd();
    ctl_t w = '0;
    w.store_reg = 1'b1;
    return w;
  endfunction

  function automatic ctl_t w_loadwb();
    ctl_t w = '0;
    w.choose_result = 2'b10;
    w.reg_write     = 1'b1;
    return w;
  endfunction

  function automatic ctl_t w_memwr();
    ctl_t w = '0;
    w.store_reg  = 1'b1;
    w.write_data = 1'b1;
    return w;
  endfunction

  function automatic ctl_t w_branch();
    ctl_t w = '0;
    w.pcen      = 1'b1;
    w.branch_en = 1'b1;
    return w;
  endfunction

  function automatic ctl_t w_jump();
    ctl_t w = '0;
    w.pcen    = 1'b1;
    w.jump_en = 1'b1;
    return w;
  endfunction

  function automatic ctl_t w_jal();
    ctl_t w = '0;
    w.pcen          = 1'b1;
    w.jal_en        = 1'b1;
    w.jump_en       = 1'b1;
    w.choose_result = 2'b11;
    w.reg_write     = 1'b1;
    return w;
  endfunction

  function automatic ctl_t w_pcinc();
    ctl_t w = '0;
    w.pcen        = 1'b1;
    w.pc_instr    = 1'b1;
    w.update_addr = 1'b1;
    w.result_en   = 1'b1;
    return w;
  endfunction

  task automatic expect_word(input ctl_t w, input string lbl);
    exp_q.push_back(w);
    lbl_q.push_back(lbl);
  endtask

  task automatic checkOutput(input ctl_t got, input ctl_t want, input string lbl);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", lbl, got, want);
    end
  endtask

  // Drive one instruction from its FETCH cycle and let it run n cycles.
  task automatic applyStimulus(input logic [15:0] instr, input logic [7:0] psr, input int n);
    ctl.memdata = instr;
    ctl.PSROut  = psr;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_lbl = lbl_q.pop_front();
      checkOutput(act, mon_exp, mon_lbl);
    end
    if (reset) begin
      checks++;
      if ($countones({ctl.BranchEN, ctl.jumpEN, ctl.PCinstruction}) > 1) begin
        errors++;
        $display("[TB] FAIL pc_src_onehot: got %b expected at most one set",
                 {ctl.BranchEN, ctl.jumpEN, ctl.PCinstruction});
      end
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    ctl.memdata = '0;
    ctl.PSROut  = '0;
    @(posedge clk); #1;
    expect_word('0, "reset_0");
    expect_word('0, "reset_1");
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;

    expect_word(w_fetch(), "add_fetch");
    expect_word(w_decode(1'b0), "add_decode");
    expect_word(w_exec(4'b0101, 1'b1, 1'b0, 1'b1), "add_exec");
    expect_word(w_pcinc(), "add_pcinc");
    applyStimulus(16'h0152, 8'h00, 4);

    expect_word(w_fetch(), "addi_fetch");
    expect_word(w_decode(1'b0), "addi_decode");
    expect_word(w_exec(4'b0101, 1'b0, 1'b0, 1'b1), "addi_exec");
    expect_word(w_pcinc(), "addi_pcinc");
    applyStimulus(16'h5101, 8'h00, 4);

    expect_word(w_fetch(), "cmp_fetch");
    expect_word(w_decode(1'b0), "cmp_decode");
    expect_word(w_exec(4'b1011, 1'b1, 1'b0, 1'b0), "cmp_exec");
    expect_word(w_pcinc(), "cmp_pcinc");
    applyStimulus(16'h01B2, 8'h00, 4);

    expect_word(w_fetch(), "ori_fetch");
    expect_word(w_decode(1'b0), "ori_decode");
    expect_word(w_exec(4'b0010, 1'b0, 1'b1, 1'b1), "ori_exec");
    expect_word(w_pcinc(), "ori_pcinc");
    applyStimulus(16'h2380, 8'h00, 4);

    expect_word(w_fetch(), "beq_t_fetch");
    expect_word(w_decode(1'b0), "beq_t_decode");
    expect_word(w_branch(), "beq_t_branch");
    applyStimulus(16'hC0FE, 8'h10, 3);

    expect_word(w_fetch(), "beq_nt_fetch");
    expect_word(w_decode(1'b0), "beq_nt_decode");
    expect_word(w_pcinc(), "beq_nt_pcinc");
    applyStimulus(16'hC0FE, 8'h00, 3);

    expect_word(w_fetch(), "blo_fetch");
    expect_word(w_decode(1'b0), "blo_decode");
    expect_word(w_branch(), "blo_branch");
    applyStimulus(16'hCA05, 8'h00, 3);

    expect_word(w_fetch(), "bhs_nt_fetch");
    expect_word(w_decode(1'b0), "bhs_nt_decode");
    expect_word(w_pcinc(), "bhs_nt_pcinc");
    applyStimulus(16'hCB05, 8'h09, 3);

    expect_word(w_fetch(), "jal_fetch");
    expect_word(w_decode(1'b0), "jal_decode");
    expect_word(w_jal(), "jal_exec");
    applyStimulus(16'h4384, 8'h00, 3);

    expect_word(w_fetch(), "juc_fetch");
    expect_word(w_decode(1'b0), "juc_decode");
    expect_word(w_jump(), "juc_jump");
    applyStimulus(16'h4EC3, 8'h00, 3);

    expect_word(w_fetch(), "jnv_fetch");
    expect_word(w_decode(1'b0), "jnv_decode");
    expect_word(w_pcinc(), "jnv_pcinc");
    applyStimulus(16'h4FC3, 8'h1F, 3);

    expect_word(w_fetch(), "load_fetch");
    expect_word(w_decode(1'b0), "load_decode");
    expect_word(w_memrd(), "load_memrd");
    expect_word(w_loadwb(), "load_wb");
    expect_word(w_pcinc(), "load_pcinc");
    applyStimulus(16'h4102, 8'h00, 5);

    expect_word(w_fetch(), "stor_fetch");
    expect_word(w_decode(1'b0), "stor_decode");
    expect_word(w_memwr(), "stor_memwr");
    expect_word(w_pcinc(), "stor_pcinc");
    applyStimulus(16'h4142, 8'h00, 4);

    expect_word(w_fetch(), "lshr_fetch");
    expect_word(w_decode(1'b0), "lshr_decode");
    expect_word(w_shift(16'h0000, 8'd3), "lshr_shift");
    expect_word(w_pcinc(), "lshr_pcinc");
    applyStimulus(16'h831D, 8'h00, 4);

    expect_word(w_fetch(), "lshl_fetch");
    expect_word(w_decode(1'b0), "lshl_decode");
    expect_word(w_shift(16'hFFFF, 8'd5), "lshl_shift");
    expect_word(w_pcinc(), "lshl_pcinc");
    applyStimulus(16'h8205, 8'h00, 4);

    expect_word(w_fetch(), "lshr16_fetch");
    expect_word(w_decode(1'b0), "lshr16_decode");
    expect_word(w_shift(16'h0000, 8'd16), "lshr16_shift");
    expect_word(w_pcinc(), "lshr16_pcinc");
    applyStimulus(16'h8110, 8'h00, 4);

    expect_word(w_fetch(), "ill_fetch");
    expect_word(w_decode(1'b1), "ill_decode");
    expect_word(w_pcinc(), "ill_pcinc");
    applyStimulus(16'hF000, 8'h00, 3);

    // Reset dropped in the middle of the MEMWR cycle of a store.
    expect_word(w_fetch(), "rst_stor_fetch");
    expect_word(w_decode(1'b0), "rst_stor_decode");
    expect_word(w_memwr(), "rst_stor_memwr");
    applyStimulus(16'h4142, 8'h00, 2);
    #5;
    reset = 1'b0;
    #1;
    checkOutput(act, '0, "reset_midop_immediate");
    @(posedge clk); #1;
    expect_word('0, "reset_hold_0");
    expect_word('0, "reset_hold_1");
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;

    expect_word(w_fetch(), "post_rst_fetch");
    expect_word(w_decode(1'b0), "post_rst_decode");
    expect_word(w_exec(4'b0101, 1'b1, 1'b0, 1'b1), "post_rst_exec");
    expect_word(w_pcinc(), "post_rst_pcinc");
    expect_word(w_fetch(), "post_rst_refetch");
    applyStimulus(16'h0152, 8'h00, 4);
    repeat (2) @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
